// File: rtl/pcie_phy_pkg.sv
// Shared constants and types for the PCIe lane serializer/deserializer pair.
package pcie_phy_pkg;

    // K28.5 comma symbol, used as the idle and byte-alignment marker.
    localparam logic [7:0] K28_5 = 8'hBC;

    // Consecutive aligned commas required before the lane is declared active.
    localparam int LOCK_COUNT_DEFAULT = 4;

    // Serial bits per symbol on the lane.
    localparam int BITS_PER_BYTE = 8;

    // Receiver alignment state machine encoding.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

endpackage : pcie_phy_pkg

// File: rtl/serial_to_parallel_rx.sv
// Receive-side deserializer: finds the byte boundary from the comma symbol,
// locks after LOCK_COUNT consecutive aligned commas, then presents each
// received byte in parallel with a valid flag (commas are idles, not data).
module serial_to_parallel_rx
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0] COMMA      = K28_5,
    parameter int          LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       in,
    output logic [7:0] out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam int                BC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [BC_W-1:0]   BC_MAX  = BC_W'(LOCK_COUNT);
    localparam logic [BC_W-1:0]   BC_LAST = BC_W'(LOCK_COUNT - 1);
    localparam logic [2:0]        BIT_TOP = 3'(BITS_PER_BYTE - 1);

    // Only the seven most recent bits are ever read: together with the bit
    // on the input they form the full 8-bit window.
    logic [6:0]      sr_q;
    logic [6:0]      sr_d;
    logic [2:0]      bit_cnt_q;
    logic [2:0]      bit_cnt_d;
    logic [BC_W-1:0] bc_cnt_q;
    rx_state_e       state_q;

    logic [7:0]      out_q;
    logic            valid_q;
    logic            strobe_q;
    logic            active_q;

    logic [7:0]      win;
    logic            win_is_comma;
    logic            at_boundary;

    assign win          = {sr_q, in};
    assign win_is_comma = (win == COMMA);
    assign at_boundary  = (bit_cnt_q == BIT_TOP);

    // Next-state for the shift window and the bit-position counter.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sr_d      = win[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if ((state_q == SEARCH) && win_is_comma) begin
            // The comma just completed defines the boundary phase.
            bit_cnt_d = 3'd0;
        end
    end

    // Datapath registers: shift window and bit counter.
    always_ff @(posedge clk32f) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Alignment FSM with registered outputs.
    always_ff @(posedge clk32f) begin
        if (reset) begin
            state_q  <= SEARCH;
            bc_cnt_q <= '0;
            out_q    <= 8'h00;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                SEARCH: begin
                    // Any comma window, aligned or not, is a candidate.
                    if (win_is_comma) begin
                        state_q  <= ALIGN;
                        bc_cnt_q <= BC_W'(1);
                    end
                end

                ALIGN: begin
                    if (at_boundary) begin
                        if (win_is_comma) begin
                            if (bc_cnt_q != BC_MAX) begin
                                bc_cnt_q <= bc_cnt_q + BC_W'(1);
                            end
                            if (bc_cnt_q == BC_LAST) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            // Candidate boundary was wrong; hunt again.
                            state_q  <= SEARCH;
                            bc_cnt_q <= '0;
                        end
                    end
                end

                ACTIVE: begin
                    // No loss-of-lock detection: only reset leaves ACTIVE.
                    if (at_boundary) begin
                        strobe_q <= 1'b1;
                        if (win_is_comma) begin
                            valid_q <= 1'b0;
                        end else begin
                            out_q   <= win;
                            valid_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q  <= SEARCH;
                    bc_cnt_q <= '0;
                end
            endcase
        end
    end

    assign out         = out_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule : serial_to_parallel_rx

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: directed scenarios with
// literal expectations plus randomized streams, all compared every edge
// against a bit-history reference model.
module tb_serial_to_parallel_rx;
    import pcie_phy_pkg::*;

    localparam logic [7:0] COMMA = K28_5;
    localparam int         LOCK  = LOCK_COUNT_DEFAULT;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b1;
    logic       in     = 1'b0;
    logic [7:0] out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    serial_to_parallel_rx #(.COMMA(COMMA), .LOCK_COUNT(LOCK)) dut (
        .clk32f      (clk32f),
        .reset       (reset),
        .in          (in),
        .out         (out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk32f = ~clk32f;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: keeps the raw bit history since reset and reasons in
    // terms of edge numbers (boundaries are multiples of 8 edges after the
    // edge that completed the first comma).
    localparam int HUNTING = 0;
    localparam int COUNTING = 1;
    localparam int LOCKED = 2;

    int         m_mode   = HUNTING;
    int         m_edge   = 0;
    int         m_anchor = 0;
    int         m_commas = 0;
    bit         m_hist[$];
    logic [7:0] e_out    = 8'h00;
    logic       e_valid  = 1'b0;
    logic       e_strobe = 1'b0;
    logic       e_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_step(input bit b, input bit r);
        logic [7:0] w;
        if (r) begin
            m_mode   = HUNTING;
            m_edge   = 0;
            m_commas = 0;
            m_hist.delete();
            e_out    = 8'h00;
            e_valid  = 1'b0;
            e_strobe = 1'b0;
            e_active = 1'b0;
            return;
        end
        m_edge++;
        m_hist.push_back(b);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        w = 8'h00;
        foreach (m_hist[i]) w = {w[6:0], m_hist[i]};
        e_strobe = 1'b0;
        if (m_mode == HUNTING) begin
            if (w == COMMA) begin
                m_mode   = COUNTING;
                m_anchor = m_edge;
                m_commas = 1;
            end
        end else if ((m_edge - m_anchor) % 8 == 0) begin
            if (m_mode == COUNTING) begin
                if (w == COMMA) begin
                    m_commas++;
                    if (m_commas == LOCK) begin
                        m_mode   = LOCKED;
                        e_active = 1'b1;
                    end
                end else begin
                    m_mode = HUNTING;
                end
            end else begin
                e_strobe = 1'b1;
                if (w == COMMA) e_valid = 1'b0;
                else begin
                    e_valid = 1'b1;
                    e_out   = w;
                end
            end
        end
    endfunction

    // One bit edge: drive, clock, advance model, then compare all outputs.
    task automatic step(input bit b, input bit r);
        in    = b;
        reset = r;
        @(posedge clk32f);
        model_step(b, r);
        #1;
        check($sformatf("active@%0d", m_edge), active, e_active);
        check($sformatf("out@%0d", m_edge), out, e_out);
        check($sformatf("valid@%0d", m_edge), valid_out, e_valid);
        check($sformatf("strobe@%0d", m_edge), byte_strobe, e_strobe);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b0, 1'b1);
    endtask

    task automatic lock_up();
        repeat (LOCK) send_byte(COMMA);
    endtask

    initial begin
        logic [7:0] b;

        // Basic lock.
        do_reset(2);
        check("rst_active", active, 0);
        check("rst_out", out, 8'h00);
        check("rst_valid", valid_out, 0);
        check("rst_strobe", byte_strobe, 0);
        repeat (3) send_byte(COMMA);
        check("basic_no_lock_24", active, 0);
        send_byte(COMMA);
        check("basic_lock_edge", m_edge, 32);
        check("basic_active_32", active, 1);
        check("basic_no_strobe_on_lock", byte_strobe, 0);
        send_byte(8'hAA);
        check("basic_out_AA", out, 8'hAA);
        check("basic_valid_40", valid_out, 1);
        check("basic_strobe_40", byte_strobe, 1);
        send_byte(8'hEE);
        check("basic_out_EE", out, 8'hEE);

        // Misaligned start.
        do_reset(1);
        step(1, 0); step(0, 0); step(1, 0);
        repeat (3) send_byte(COMMA);
        for (int i = 7; i > 0; i--) step(COMMA[i], 0);
        check("mis_no_lock_34", active, 0);
        step(COMMA[0], 0);
        check("mis_lock_35", active, 1);
        send_byte(8'hAA);
        check("mis_edge_43", m_edge, 43);
        check("mis_out_43", out, 8'hAA);
        check("mis_valid_43", valid_out, 1);
        check("mis_strobe_43", byte_strobe, 1);

        // Broken alignment.
        do_reset(1);
        send_byte(COMMA); send_byte(COMMA); send_byte(8'h00);
        check("broken_active_24", active, 0);
        repeat (3) send_byte(COMMA);
        check("broken_no_lock_48", active, 0);
        send_byte(COMMA);
        check("broken_relock_56", active, 1);

        // Idle in ACTIVE.
        do_reset(1);
        lock_up();
        send_byte(8'hAA);
        check("idle_strobe_1", byte_strobe, 1);
        check("idle_valid_1", valid_out, 1);
        check("idle_out_1", out, 8'hAA);
        send_byte(COMMA);
        check("idle_strobe_2", byte_strobe, 1);
        check("idle_valid_2", valid_out, 0);
        check("idle_out_2", out, 8'hAA);
        send_byte(8'hCC);
        check("idle_strobe_3", byte_strobe, 1);
        check("idle_valid_3", valid_out, 1);
        check("idle_out_3", out, 8'hCC);

        // False comma across bytes, then an aligned lock at the original phase.
        do_reset(1);
        send_byte(8'h5E); send_byte(8'h00); send_byte(8'h00);
        check("false_active_24", active, 0);
        lock_up();
        check("false_lock_56", active, 1);

        // Reset mid-byte in ACTIVE.
        do_reset(1);
        lock_up();
        send_byte(8'hAA);
        step(1, 0); step(0, 0); step(1, 0);
        step(0, 1);
        check("midrst_active", active, 0);
        check("midrst_valid", valid_out, 0);
        check("midrst_strobe", byte_strobe, 0);
        check("midrst_out", out, 8'h00);
        repeat (3) send_byte(COMMA);
        check("midrst_no_lock_24", active, 0);
        send_byte(COMMA);
        check("midrst_relock_32", active, 1);

        // Randomized streams, checked every edge by the model.
        for (int t = 0; t < 30; t++) begin
            do_reset(1 + int'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 12)) step(1'($urandom), 0);
            for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
                b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : COMMA;
                send_byte(b);
            end
            for (int k = 0; k < 10; k++) begin
                b = ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom);
                send_byte(b);
                if ($urandom_range(0, 15) == 0) step(1'($urandom), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_serial_to_parallel_rx
